// File: rtl/gpio_in_filter.sv
// 8-bit GPIO input conditioner: two-flop synchronizer, prescaled per-bit debounce, sticky edge flags.
// Edge flags and the interrupt exist only when GPIO_IN_FILTER_EDGE_EN is defined.
module gpio_in_filter #(
   parameter int unsigned PRESCALE    = 1,
   parameter int unsigned STABLE_CNT  = 4,
   parameter logic [7:0]  RESET_LEVEL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pin_i,
   output logic [7:0] gpio_o,
   output logic [7:0] rise_o,
   output logic [7:0] fall_o,
   input  logic [7:0] clr_i,
   input  logic [7:0] irq_mask_i,
   output logic       irq_o
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
   localparam logic [7:0]  DC_LAST = 8'(STABLE_CNT - 1);

   logic [7:0]  s1;
   logic [7:0]  s2;
   logic [7:0]  stable;
   logic [15:0] pcnt;
   logic        tick;
   logic [7:0]  dcnt [8];
   logic [7:0]  accept;

   // Stage: pad synchronizer
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= RESET_LEVEL;
         s2 <= RESET_LEVEL;
      end else begin
         s1 <= pin_i;
         s2 <= s1;
      end
   end

   // Stage: sample-tick prescaler
   assign tick = (pcnt == PS_LAST);

   always_ff @(posedge clk) begin
      if (reset || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   // A bit is accepted when it has differed for STABLE_CNT ticks, this tick included.
   always_comb begin
      accept = '0;
      for (int i = 0; i < 8; i++) begin
         accept[i] = tick && (s2[i] != stable[i]) && (dcnt[i] == DC_LAST);
      end
   end

   // Stage: per-bit debounce
   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= RESET_LEVEL;
         for (int i = 0; i < 8; i++) begin
            dcnt[i] <= '0;
         end
      end else if (tick) begin
         for (int i = 0; i < 8; i++) begin
            if (s2[i] == stable[i]) begin
               dcnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= s2[i];
               dcnt[i]   <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 8'd1;
            end
         end
      end
   end

   assign gpio_o = stable;

`ifdef GPIO_IN_FILTER_EDGE_EN
   logic [7:0] rise_q;
   logic [7:0] fall_q;
   logic [7:0] rise_set;
   logic [7:0] fall_set;

   // Flags set on the same edge that stable changes, so they line up with gpio_o.
   assign rise_set = accept & s2;
   assign fall_set = accept & ~s2;

   // Stage: sticky edge flags (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= (rise_q & ~clr_i) | rise_set;
         fall_q <= (fall_q & ~clr_i) | fall_set;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign irq_o  = |((rise_q | fall_q) & irq_mask_i);
`else
   logic unused_edge;

   assign unused_edge = ^{clr_i, irq_mask_i};
   assign rise_o      = '0;
   assign fall_o      = '0;
   assign irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: three instances cover default, prescaled and RESET_LEVEL=FF builds.
// Flag expectations follow GPIO_IN_FILTER_EDGE_EN so the same bench covers both builds.
module tb_gpio_in_filter;

`ifdef GPIO_IN_FILTER_EDGE_EN
   localparam logic [7:0] EN  = 8'hFF;
   localparam logic       IEN = 1'b1;
`else
   localparam logic [7:0] EN  = 8'h00;
   localparam logic       IEN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   logic       reset_a, reset_b, reset_c;
   logic [7:0] pin_a, clr_a, mask_a, gpio_a, rise_a, fall_a;
   logic [7:0] pin_b, clr_b, mask_b, gpio_b, rise_b, fall_b;
   logic [7:0] pin_c, clr_c, mask_c, gpio_c, rise_c, fall_c;
   logic       irq_a, irq_b, irq_c;

   gpio_in_filter #(.PRESCALE(1), .STABLE_CNT(4), .RESET_LEVEL(8'h00)) dut_a (
      .clk(clk), .reset(reset_a), .pin_i(pin_a), .gpio_o(gpio_a), .rise_o(rise_a),
      .fall_o(fall_a), .clr_i(clr_a), .irq_mask_i(mask_a), .irq_o(irq_a));

   gpio_in_filter #(.PRESCALE(10), .STABLE_CNT(2), .RESET_LEVEL(8'h00)) dut_b (
      .clk(clk), .reset(reset_b), .pin_i(pin_b), .gpio_o(gpio_b), .rise_o(rise_b),
      .fall_o(fall_b), .clr_i(clr_b), .irq_mask_i(mask_b), .irq_o(irq_b));

   gpio_in_filter #(.PRESCALE(1), .STABLE_CNT(4), .RESET_LEVEL(8'hFF)) dut_c (
      .clk(clk), .reset(reset_c), .pin_i(pin_c), .gpio_o(gpio_c), .rise_o(rise_c),
      .fall_o(fall_c), .clr_i(clr_c), .irq_mask_i(mask_c), .irq_o(irq_c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n active edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int  t0, t1;
      bit  found;

      reset_a = 1; reset_b = 1; reset_c = 1;
      pin_a = 8'h00; pin_b = 8'h00; pin_c = 8'hFF;
      clr_a = 8'h00; clr_b = 8'h00; clr_c = 8'h00;
      mask_a = 8'h00; mask_b = 8'h00; mask_c = 8'hFF;
      step(2);
      reset_a = 0; reset_b = 0; reset_c = 0;

      chk("rst_gpio_a", gpio_a, 8'h00);
      chk("rst_rise_a", rise_a, 8'h00);
      chk("rst_fall_a", fall_a, 8'h00);
      chk("rst_irq_a",  irq_a,  1'b0);
      chk("rst_gpio_b", gpio_b, 8'h00);
      chk("rst_gpio_c", gpio_c, 8'hFF);
      chk("rst_irq_c",  irq_c,  1'b0);

      // Rising edge on bit 0: visible on the 6th edge, flag in the same cycle
      pin_a = 8'h01;
      step(5);
      chk("rise0_gpio_e5", gpio_a, 8'h00);
      chk("rise0_flag_e5", rise_a, 8'h00);
      step(1);
      chk("rise0_gpio_e6", gpio_a, 8'h01);
      chk("rise0_flag_e6", rise_a, 8'h01 & EN);
      chk("rise0_irq_nomask", irq_a, 1'b0);
      mask_a = 8'h01;
      #1;
      chk("rise0_irq_mask", irq_a, IEN);
      mask_a = 8'h00;
      #1;
      chk("rise0_irq_unmask", irq_a, 1'b0);

      clr_a = 8'hFF;
      step(1);
      clr_a = 8'h00;
      chk("clr_all_rise", rise_a, 8'h00);

      // Two 3-cycle glitches on bit 3 separated by one low cycle: nothing accepted
      pin_a = 8'h09; step(3);
      pin_a = 8'h01; step(1);
      pin_a = 8'h09; step(3);
      pin_a = 8'h01;
      for (int i = 0; i < 8; i++) begin
         chk("glitch_gpio", gpio_a, 8'h01);
         step(1);
      end
      chk("glitch_rise", rise_a, 8'h00);
      chk("glitch_fall", fall_a, 8'h00);

      // Falling edge on bit 0
      pin_a = 8'h00;
      step(5);
      chk("fall0_gpio_e5", gpio_a, 8'h01);
      step(1);
      chk("fall0_gpio_e6", gpio_a, 8'h00);
      chk("fall0_flag", fall_a, 8'h01 & EN);
      chk("fall0_rise", rise_a, 8'h00);
      clr_a = 8'hFF; step(1); clr_a = 8'h00;
      chk("clr_all_fall", fall_a, 8'h00);

      // Bit 2: rise, fall (both sticky), then clear collides with a new rise
      pin_a = 8'h04; step(6);
      chk("b2_rise_gpio", gpio_a, 8'h04);
      chk("b2_rise_flag", rise_a, 8'h04 & EN);
      pin_a = 8'h00; step(6);
      chk("b2_fall_gpio", gpio_a, 8'h00);
      chk("b2_sticky_rise", rise_a, 8'h04 & EN);
      chk("b2_fall_flag", fall_a, 8'h04 & EN);
      pin_a = 8'h04; step(5);
      clr_a = 8'h04; step(1);
      clr_a = 8'h00;
      chk("b2_coll_gpio", gpio_a, 8'h04);
      chk("b2_coll_rise", rise_a, 8'h04 & EN);
      chk("b2_coll_fall", fall_a, 8'h00);
      mask_a = 8'h04; #1;
      chk("b2_irq", irq_a, IEN);
      clr_a = 8'h04; step(1); clr_a = 8'h00;
      chk("b2_clr_rise", rise_a, 8'h00);
      chk("b2_clr_irq", irq_a, 1'b0);
      mask_a = 8'h00;

      // Prescaled instance: measure tick period, then align pin change to a tick
      t0 = -1; t1 = -1;
      for (int i = 0; i < 40; i++) begin
         if (dut_b.tick) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
         end
         step(1);
      end
      chk("tick_period", t1 - t0, 10);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dut_b.tick) found = 1;
         else step(1);
      end
      chk("tick_found", found, 1'b1);
      // Next edge is a tick: s2 high after 2 edges, ticks at edges 11 and 21
      pin_b = 8'h80;
      step(20);
      chk("ps_gpio_e20", gpio_b, 8'h00);
      step(1);
      chk("ps_gpio_e21", gpio_b, 8'h80);
      chk("ps_rise", rise_b, 8'h80 & EN);

      // RESET_LEVEL=FF instance: reset in the middle of a count discards it
      pin_c = 8'h00; step(4);
      reset_c = 1; pin_c = 8'hFF; step(1);
      reset_c = 0;
      chk("rl_gpio_post", gpio_c, 8'hFF);
      chk("rl_fall_post", fall_c, 8'h00);
      chk("rl_irq_post",  irq_c,  1'b0);
      pin_c = 8'h00; step(3);
      pin_c = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         chk("rl_gpio", gpio_c, 8'hFF);
         step(1);
      end
      chk("rl_fall", fall_c, 8'h00);
      chk("rl_rise", rise_c, 8'h00);
      chk("rl_irq",  irq_c,  1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
